tb_qspi_mem_model: RTL and testbench
====================================

// Module: tb_qspi_mem_model
// PURPOSE
// Parametrised clk-synchronous SPI/QSPI memory model for the top-level bench. It sits on
// the uio pins beside the tt_um wrapper and serves N_CS chip-selects (flash, RAM, ...).
// Each chip-select has its own byte region. It decodes serial and quad read/write
// commands and has a backdoor port for preload and checking. Intended for RTL and GL sims.
// PARAMETERS
// N_CS        2   number of chip-selects / memory regions
// DEPTH_LOG2  12  log2 bytes per region; address wraps modulo 2**DEPTH_LOG2
// ADDR_BYTES  3   address bytes sent after the command (upper bits beyond DEPTH_LOG2 ignored)
// DUMMY_CYC   4   SCK cycles between address and data for 0xEB
// WR_MASK     2'b10  bit i=1: region i writable over SPI (backdoor always writes)
// PORTS
// clk        in   1                  bench clock; all state updates on posedge
// rst_n      in   1                  asynchronous active-low reset
// cs_n       in   N_CS               chip-selects, active low
// sck        in   1                  SPI clock, sampled by clk; high and low phases >=1 clk each
// sd_in      in   4                  IO[3:0] from DUT
// sd_out     out  4                  IO[3:0] to DUT
// sd_oe      out  4                  per-bit drive enable
// bd_we      in   1                  backdoor write strobe
// bd_addr    in   $clog2(N_CS)+DEPTH_LOG2  {region,byte address}
// bd_wdata   in   8                  backdoor write data
// bd_rdata   out  8                  combinational read of bd_addr
// err        out  1                  sticky protocol-error flag
// BEHAVIOUR
// - Reset: sd_out=0, sd_oe=0, err=0, FSM=IDLE, counters 0. Memory array is not cleared.
// - Edge detect: sck_q<=sck. rise=sck&~sck_q, fall=~sck&sck_q. Mode 0 only.
//   - Input bits are sampled on rise.
//   - Outputs update on the clk edge that registers fall.
// - Bit order: MSB first. Quad nibbles are high-nibble first, with sd[3] as the MSB.
// - FSM: IDLE -> CMD -> ADDR -> (DUMMY) -> RDATA | WDATA. ERR is also reachable.
//   - IDLE: exactly one cs_n low selects region r and enters CMD. More than one low: ERR, err<=1.
//   - CMD: 8 serial bits on sd_in[0]. Decode:
//     - 0x03: read, serial address, serial data.
//     - 0xEB: read, quad address, DUMMY_CYC dummy cycles, quad data.
//     - 0x02: write, serial address, serial data.
//     - 0x38: write, quad address, quad data.
//     - Any other value: ERR, err<=1.
//   - ADDR: 8*ADDR_BYTES bits, serial (1 bit/rise) or quad (4 bits/rise).
//   - DUMMY: counts DUMMY_CYC rises. sd_oe stays 0.
//   - RDATA serial: sd_oe=4'b0010, data on sd_out[1].
//     - First bit is driven on the fall after the last address rise.
//     - Address auto-increments per byte and wraps at 2**DEPTH_LOG2 back to 0.
//   - RDATA quad: sd_oe=4'b1111, one nibble per fall.
//     - The first nibble follows the fall after the last dummy rise.
//   - WDATA: bytes are assembled from rises. Each completed byte writes mem[r][addr], then addr+1 with wrap.
//     - Region not writable (WR_MASK[r]=0): byte is dropped and err<=1. The FSM keeps counting.
//   - ERR: sd_oe=0. Remains until every cs_n is high.
// - cs_n of the selected region rising, in any state:
//   - Next clk: IDLE, sd_oe=0.
//   - A partially received byte is discarded. Completed bytes stay written.
// - The selected cs_n stays low and another goes low mid-transfer: ERR, err<=1.
// - Backdoor write and SPI byte-write hit the same location in the same clk: backdoor wins.
// - bd_rdata reflects array content, including SPI writes, from the clk after the write.
// - err clears only on reset.
// - Reset asserted mid-transfer: outputs go to reset values immediately (async). Memory is kept.
// TESTING
// 1. Backdoor preload r0[0x010..0x013]=DE AD BE EF; 0x03 addr 0x000010, 32 SCK -> sd_out[1] serial DEADBEEF, sd_oe=0010.
// 2. Preload r0[0xFFE..0xFFF]=11 22, r0[0x000]=33; 0xEB addr 0x000FFE, 4 dummy, 6 nibbles -> 1,1,2,2,3,3 (wrap).
// 3. cs_n[1]: 0x38 addr 0x000100, data A5 5A -> bd_rdata at 1:0x100=A5, 1:0x101=5A, err=0.
// 4. cs_n[0]: 0x02 addr 0x000020, data 77 -> r0[0x020] unchanged, err=1.
// 5. Unknown cmd 0x9F -> sd_oe=0 throughout, err=1. Then cs_n high and a 0x03 read returns correct data.
// 6. 0x02 to r1 with cs_n raised after 12 data bits: 1st byte written, 2nd dropped, FSM back in IDLE next clk.
//    Then rst_n pulse mid-0xEB read: sd_oe=0 at once, data kept.

Source files
------------

// File: rtl/tb_qspi_mem_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_qspi_mem_model
// Brief    : clk-synchronous SPI/QSPI memory model, N_CS regions, backdoor port
// Revision : 1.0 - initial release
// ============================================================================
module tb_qspi_mem_model #(
  parameter int              N_CS       = 2,
  parameter int              DEPTH_LOG2 = 12,
  parameter int              ADDR_BYTES = 3,
  parameter int              DUMMY_CYC  = 4,
  parameter logic [N_CS-1:0] WR_MASK    = 2'b10
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [N_CS-1:0]                    cs_n,
  input  logic                               sck,
  input  logic [3:0]                         sd_in,
  output logic [3:0]                         sd_out,
  output logic [3:0]                         sd_oe,
  input  logic                               bd_we,
  input  logic [$clog2(N_CS)+DEPTH_LOG2-1:0] bd_addr,
  input  logic [7:0]                         bd_wdata,
  output logic [7:0]                         bd_rdata,
  output logic                               err
);

  localparam int c_RW    = $clog2(N_CS);
  localparam int c_RGW   = (c_RW > 0) ? c_RW : 1;
  localparam int c_AW    = c_RW + DEPTH_LOG2;
  localparam int c_AB    = 8 * ADDR_BYTES;
  localparam int c_DEPTH = N_CS << DEPTH_LOG2;

  localparam logic [7:0] c_ADDR_SER_LAST  = 8'(c_AB - 1);
  localparam logic [7:0] c_ADDR_QUAD_LAST = 8'(2 * ADDR_BYTES - 1);
  localparam logic [7:0] c_DUMMY_LAST     = 8'(DUMMY_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_ADDR  = 3'd2,
    S_DUMMY = 3'd3,
    S_RDATA = 3'd4,
    S_WDATA = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t            r_state, w_state;
  logic              r_sck_q;
  logic [c_RGW-1:0]  r_region, w_region;
  logic [7:0]        r_cnt, w_cnt;
  logic [c_AB-1:0]   r_sh, w_sh;
  logic              r_quad, w_quad;
  logic              r_write, w_write;
  logic [DEPTH_LOG2-1:0] r_addr, w_addr;
  logic [7:0]        r_byte, w_byte;
  logic [3:0]        w_sd_out, w_sd_oe;
  logic              w_err;

  logic [7:0]        r_mem [c_DEPTH];

  logic              w_rise, w_fall;
  logic [c_AW-1:0]   w_cur_idx;
  logic [7:0]        w_rd_byte;
  logic              w_wr_en;
  logic [7:0]        w_wr_data;
  logic [7:0]        w_n_low;
  logic [c_RGW-1:0]  w_low_idx;
  logic [N_CS-1:0]   w_sel_mask;
  logic              w_other_low;
  logic [c_AB-1:0]   w_sh_ser, w_sh_quad;
  logic [7:0]        w_byte_ser, w_byte_quad;

  assign w_rise      = sck & ~r_sck_q;
  assign w_fall      = ~sck & r_sck_q;
  assign w_cur_idx   = c_AW'({r_region, r_addr});
  assign w_rd_byte   = r_mem[w_cur_idx];
  assign bd_rdata    = r_mem[bd_addr];
  assign w_sh_ser    = {r_sh[c_AB-2:0], sd_in[0]};
  assign w_sh_quad   = {r_sh[c_AB-5:0], sd_in};
  assign w_byte_ser  = {r_byte[6:0], sd_in[0]};
  assign w_byte_quad = {r_byte[3:0], sd_in};

  // Chip-select census: how many are low, which one, and whether a foreign one is low
  always_comb begin
    w_n_low    = 8'd0;
    w_low_idx  = '0;
    w_sel_mask = '0;
    for (int i = 0; i < N_CS; i++) begin
      if (!cs_n[i]) begin
        w_n_low   = w_n_low + 8'd1;
        w_low_idx = c_RGW'(i);
      end
    end
    w_sel_mask[r_region] = 1'b1;
    w_other_low = |(~cs_n & ~w_sel_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_sck_q  <= 1'b0;
      r_region <= '0;
      r_cnt    <= 8'd0;
      r_sh     <= '0;
      r_quad   <= 1'b0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_byte   <= 8'd0;
      sd_out   <= 4'd0;
      sd_oe    <= 4'd0;
      err      <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_sck_q  <= sck;
      r_region <= w_region;
      r_cnt    <= w_cnt;
      r_sh     <= w_sh;
      r_quad   <= w_quad;
      r_write  <= w_write;
      r_addr   <= w_addr;
      r_byte   <= w_byte;
      sd_out   <= w_sd_out;
      sd_oe    <= w_sd_oe;
      err      <= w_err;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_region  = r_region;
    w_cnt     = r_cnt;
    w_sh      = r_sh;
    w_quad    = r_quad;
    w_write   = r_write;
    w_addr    = r_addr;
    w_byte    = r_byte;
    w_sd_out  = sd_out;
    w_sd_oe   = sd_oe;
    w_err     = err;
    w_wr_en   = 1'b0;
    w_wr_data = 8'd0;

    case (r_state)
      S_IDLE: begin
        w_sd_oe = 4'd0;
        if (w_n_low == 8'd1) begin
          w_state  = S_CMD;
          w_region = w_low_idx;
          w_cnt    = 8'd0;
          w_sh     = '0;
          w_quad   = 1'b0;
          w_write  = 1'b0;
          w_byte   = 8'd0;
        end else if (w_n_low > 8'd1) begin
          w_state = S_ERR;
          w_err   = 1'b1;
        end
      end

      S_CMD: begin
        if (w_rise) begin
          w_sh  = w_sh_ser;
          w_cnt = r_cnt + 8'd1;
          if (r_cnt == 8'd7) begin
            w_cnt = 8'd0;
            w_sh  = '0;
            case (w_sh_ser[7:0])
              8'h03: begin w_state = S_ADDR; w_quad = 1'b0; w_write = 1'b0; end
              8'hEB: begin w_state = S_ADDR; w_quad = 1'b1; w_write = 1'b0; end
              8'h02: begin w_state = S_ADDR; w_quad = 1'b0; w_write = 1'b1; end
              8'h38: begin w_state = S_ADDR; w_quad = 1'b1; w_write = 1'b1; end
              default: begin w_state = S_ERR; w_err = 1'b1; end
            endcase
          end
        end
      end

      S_ADDR: begin
        if (w_rise) begin
          w_sh  = r_quad ? w_sh_quad : w_sh_ser;
          w_cnt = r_cnt + 8'd1;
          if (r_cnt == (r_quad ? c_ADDR_QUAD_LAST : c_ADDR_SER_LAST)) begin
            w_cnt  = 8'd0;
            w_addr = w_sh[DEPTH_LOG2-1:0];
            if (r_write) begin
              w_state = S_WDATA;
              w_byte  = 8'd0;
            end else if (r_quad && DUMMY_CYC > 0) begin
              w_state = S_DUMMY;
            end else begin
              w_state = S_RDATA;
              w_sd_oe = r_quad ? 4'b1111 : 4'b0010;
            end
          end
        end
      end

      S_DUMMY: begin
        if (w_rise) begin
          w_cnt = r_cnt + 8'd1;
          if (r_cnt == c_DUMMY_LAST) begin
            w_cnt   = 8'd0;
            w_state = S_RDATA;
            w_sd_oe = 4'b1111;
          end
        end
      end

      S_RDATA: begin
        if (w_fall) begin
          if (r_quad) begin
            w_sd_out = r_cnt[0] ? w_rd_byte[3:0] : w_rd_byte[7:4];
            w_cnt    = r_cnt[0] ? 8'd0 : 8'd1;
            if (r_cnt[0]) w_addr = r_addr + 1'b1;
          end else begin
            w_sd_out = {2'b00, w_rd_byte[~r_cnt[2:0]], 1'b0};
            if (r_cnt == 8'd7) begin
              w_cnt  = 8'd0;
              w_addr = r_addr + 1'b1;
            end else begin
              w_cnt = r_cnt + 8'd1;
            end
          end
        end
      end

      S_WDATA: begin
        if (w_rise) begin
          w_byte = r_quad ? w_byte_quad : w_byte_ser;
          w_cnt  = r_cnt + 8'd1;
          if (r_cnt == (r_quad ? 8'd1 : 8'd7)) begin
            w_cnt  = 8'd0;
            w_addr = r_addr + 1'b1;
            if (WR_MASK[r_region]) begin
              w_wr_en   = 1'b1;
              w_wr_data = w_byte;
            end else begin
              w_err = 1'b1;
            end
          end
        end
      end

      S_ERR: begin
        w_sd_oe = 4'd0;
        if (&cs_n) w_state = S_IDLE;
      end

      default: w_state = S_IDLE;
    endcase

    // Deselect or a second chip-select overrides whatever the active state decided
    if (r_state != S_IDLE && r_state != S_ERR) begin
      if (cs_n[r_region]) begin
        w_state  = S_IDLE;
        w_sd_oe  = 4'd0;
        w_sd_out = 4'd0;
        w_cnt    = 8'd0;
        w_wr_en  = 1'b0;
      end else if (w_other_low) begin
        w_state  = S_ERR;
        w_err    = 1'b1;
        w_sd_oe  = 4'd0;
        w_sd_out = 4'd0;
        w_wr_en  = 1'b0;
      end
    end
  end

  // Backdoor write is issued last so it wins a same-address collision
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_cur_idx] <= w_wr_data;
    if (bd_we)   r_mem[bd_addr]   <= bd_wdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_tb_qspi_mem_model.sv
`default_nettype none
// Scoreboard bench for tb_qspi_mem_model: stimulus queues expected read nibbles/bits,
// a monitor on each SCK rise pops and compares whenever the model drives.
module tb_tb_qspi_mem_model;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  cs_n = 2'b11;
  logic        sck = 1'b0;
  logic [3:0]  sd_in = 4'd0;
  logic [3:0]  sd_out, sd_oe;
  logic        bd_we = 1'b0;
  logic [12:0] bd_addr = 13'd0;
  logic [7:0]  bd_wdata = 8'd0;
  logic [7:0]  bd_rdata;
  logic        err;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] oe;
    logic [3:0] mask;
    logic [3:0] val;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  tb_qspi_mem_model dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs_n     (cs_n),
    .sck      (sck),
    .sd_in    (sd_in),
    .sd_out   (sd_out),
    .sd_oe    (sd_oe),
    .bd_we    (bd_we),
    .bd_addr  (bd_addr),
    .bd_wdata (bd_wdata),
    .bd_rdata (bd_rdata),
    .err      (err)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void push_exp(input logic [3:0] oe, input logic [3:0] mask, input logic [3:0] val);
    exp_t e;
    e.oe = oe;
    e.mask = mask;
    e.val = val;
    exp_q.push_back(e);
  endfunction

  function automatic void exp_ser(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) push_exp(4'b0010, 4'b0010, {2'b00, b[i], 1'b0});
  endfunction

  function automatic void exp_quad(input logic [7:0] b);
    push_exp(4'b1111, 4'b1111, b[7:4]);
    push_exp(4'b1111, 4'b1111, b[3:0]);
  endfunction

  // Monitor: the DUT's output is stable at every SCK rise
  always @(posedge sck) begin
    if (sd_oe !== 4'b0000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_drive", {28'd0, sd_oe}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rd_oe", {28'd0, sd_oe}, {28'd0, mon_e.oe});
        check("rd_data", {28'd0, sd_out & mon_e.mask}, {28'd0, mon_e.val});
      end
    end
  end

  task automatic tick(input logic [3:0] d);
    sd_in = d;
    sck = 1'b1;
    repeat (2) @(negedge clk);
    sck = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic ser_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) tick({3'b000, b[i]});
  endtask

  task automatic quad_byte(input logic [7:0] b);
    tick(b[7:4]);
    tick(b[3:0]);
  endtask

  task automatic sel(input int r);
    cs_n = ~(2'b01 << r);
    repeat (2) @(negedge clk);
  endtask

  task automatic desel();
    sd_in = 4'd0;
    cs_n = 2'b11;
    repeat (3) @(negedge clk);
  endtask

  task automatic bd_wr(input logic r, input logic [11:0] a, input logic [7:0] d);
    bd_addr = {r, a};
    bd_wdata = d;
    bd_we = 1'b1;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic bd_chk(input string name, input logic r, input logic [11:0] a, input logic [7:0] d);
    bd_addr = {r, a};
    #1;
    check(name, {24'd0, bd_rdata}, {24'd0, d});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_sd_oe", {28'd0, sd_oe}, 32'd0);
    check("rst_sd_out", {28'd0, sd_out}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: serial read
    bd_wr(1'b0, 12'h010, 8'hDE);
    bd_wr(1'b0, 12'h011, 8'hAD);
    bd_wr(1'b0, 12'h012, 8'hBE);
    bd_wr(1'b0, 12'h013, 8'hEF);
    bd_chk("bd_preload", 1'b0, 12'h012, 8'hBE);
    sel(0);
    ser_byte(8'h03); ser_byte(8'h00); ser_byte(8'h00); ser_byte(8'h10);
    exp_ser(8'hDE); exp_ser(8'hAD); exp_ser(8'hBE); exp_ser(8'hEF);
    repeat (32) tick(4'd0);
    desel();
    check("t1_err", {31'd0, err}, 32'd0);

    // 2: quad read with wrap
    bd_wr(1'b0, 12'hFFE, 8'h11);
    bd_wr(1'b0, 12'hFFF, 8'h22);
    bd_wr(1'b0, 12'h000, 8'h33);
    sel(0);
    ser_byte(8'hEB);
    quad_byte(8'h00); quad_byte(8'h0F); quad_byte(8'hFE);
    repeat (4) tick(4'd0);
    exp_quad(8'h11); exp_quad(8'h22); exp_quad(8'h33);
    repeat (6) tick(4'd0);
    desel();

    // 3: quad write to writable region 1
    sel(1);
    ser_byte(8'h38);
    quad_byte(8'h00); quad_byte(8'h01); quad_byte(8'h00);
    quad_byte(8'hA5); quad_byte(8'h5A);
    desel();
    bd_chk("t3_r1_100", 1'b1, 12'h100, 8'hA5);
    bd_chk("t3_r1_101", 1'b1, 12'h101, 8'h5A);
    check("t3_err", {31'd0, err}, 32'd0);

    // 4: write to read-only region 0
    bd_wr(1'b0, 12'h020, 8'h5C);
    sel(0);
    ser_byte(8'h02); ser_byte(8'h00); ser_byte(8'h00); ser_byte(8'h20);
    ser_byte(8'h77);
    desel();
    bd_chk("t4_r0_020", 1'b0, 12'h020, 8'h5C);
    check("t4_err", {31'd0, err}, 32'd1);

    rst_n = 1'b0;
    @(negedge clk);
    check("rst_clears_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 5: unknown command, then recovery
    sel(0);
    ser_byte(8'h9F);
    check("t5_oe_after_cmd", {28'd0, sd_oe}, 32'd0);
    check("t5_err", {31'd0, err}, 32'd1);
    repeat (8) tick(4'hF);
    check("t5_oe_in_err", {28'd0, sd_oe}, 32'd0);
    desel();
    sel(0);
    ser_byte(8'h03); ser_byte(8'h00); ser_byte(8'h00); ser_byte(8'h10);
    exp_ser(8'hDE); exp_ser(8'hAD);
    repeat (16) tick(4'd0);
    desel();

    // 6: aborted write, then reset during a quad read
    bd_wr(1'b1, 12'h201, 8'h99);
    sel(1);
    ser_byte(8'h02); ser_byte(8'h00); ser_byte(8'h02); ser_byte(8'h00);
    ser_byte(8'hC3);
    tick(4'd0); tick(4'd0); tick(4'd1); tick(4'd1);
    cs_n = 2'b11;
    @(negedge clk);
    check("t6_oe_after_abort", {28'd0, sd_oe}, 32'd0);
    repeat (2) @(negedge clk);
    bd_chk("t6_r1_200", 1'b1, 12'h200, 8'hC3);
    bd_chk("t6_r1_201", 1'b1, 12'h201, 8'h99);
    sel(0);
    ser_byte(8'hEB);
    quad_byte(8'h00); quad_byte(8'h00); quad_byte(8'h10);
    repeat (4) tick(4'd0);
    exp_quad(8'hDE);
    repeat (2) tick(4'd0);
    check("t6_oe_before_rst", {28'd0, sd_oe}, 32'hF);
    check("t6_out_before_rst", {28'd0, sd_out}, 32'hA);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_oe_async_rst", {28'd0, sd_oe}, 32'd0);
    check("t6_out_async_rst", {28'd0, sd_out}, 32'd0);
    cs_n = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    bd_chk("t6_kept_r0_010", 1'b0, 12'h010, 8'hDE);
    bd_chk("t6_kept_r1_200", 1'b1, 12'h200, 8'hC3);
    bd_chk("t6_kept_r1_100", 1'b1, 12'h100, 8'hA5);
    check("t6_err_after_rst", {31'd0, err}, 32'd0);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
